// File: rtl/beat_ctrl_pkg.sv
// Shared types and constants for the beat controller: controller states,
// one-hot beat encodings and the mode select values.
package beat_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    B_NONE = 3'b000,
    B_T1   = 3'b001,
    B_T2   = 3'b010,
    B_T3   = 3'b100
  } beat_e;

  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_STEP = 1'b1;

endpackage

// File: rtl/fall_det.sv
// Falling-edge detector: registered previous value (reset high) and a
// one-cycle event whenever the previous value was high and the input is low.
module fall_det (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sig_i,
  output logic fall_o
);

  logic prev_q;
  logic armed_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= sig_i;
      armed_q <= 1'b1;
    end
  end

  // armed_q masks the first cycle after reset so a level held low through
  // reset release is not mistaken for a fresh press.
  assign fall_o = armed_q & prev_q & ~sig_i;

endmodule

// File: rtl/beat_ctrl.sv
// Machine-cycle beat controller: issues t1/t2/t3 beats in continuous RUN or
// single-cycle STEP mode, finishing every cycle through t3 before stopping.
module beat_ctrl
  import beat_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             nRst,
  input  logic             nSTART,
  input  logic             nSTOP,
  input  logic             mode,
  input  logic             halt,
  output logic             t1,
  output logic             t2,
  output logic             t3,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cyc_cnt
);

  state_e           state_q, state_d;
  beat_e            beat_q, beat_d;
  logic             stop_pend_q, stop_pend_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_evt, stop_evt;

  fall_det u_start_det (
    .clk_i   (CLK),
    .rst_n_i (nRst),
    .sig_i   (nSTART),
    .fall_o  (start_evt)
  );

  fall_det u_stop_det (
    .clk_i   (CLK),
    .rst_n_i (nRst),
    .sig_i   (nSTOP),
    .fall_o  (stop_evt)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        beat_d = B_NONE;
        if (start_evt && !stop_evt) begin
          state_d = (mode == MODE_STEP) ? STEP : RUN;
          beat_d  = B_T1;
        end
      end
      RUN, STEP: begin
        // A stop arriving in the t3 cycle itself still ends that cycle.
        if (state_q == RUN && stop_evt) stop_pend_d = 1'b1;
        unique case (beat_q)
          B_T1: beat_d = B_T2;
          B_T2: beat_d = B_T3;
          B_T3: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == STEP || stop_pend_d || halt) begin
              state_d     = IDLE;
              beat_d      = B_NONE;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
            end else begin
              beat_d = B_T1;
            end
          end
          default: begin
            state_d     = IDLE;
            beat_d      = B_NONE;
            stop_pend_d = 1'b0;
          end
        endcase
      end
      default: begin
        state_d     = IDLE;
        beat_d      = B_NONE;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  // NOTE: reset is synchronous and clears every state flop here; there are
  // no memories in this block that would need to be left unreset.
  always_ff @(posedge CLK) begin
    if (!nRst) begin
      state_q     <= IDLE;
      beat_q      <= B_NONE;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign t1      = beat_q[0];
  assign t2      = beat_q[1];
  assign t3      = beat_q[2];
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign cyc_cnt = cnt_q;

endmodule

// File: tb/tb_beat_ctrl.sv
// Self-checking bench for beat_ctrl: a vector table plus hand-written reset
// sequences, with expected outputs queued on drive and compared one cycle later.
module tb_beat_ctrl;

  typedef struct {
    int         id;
    logic       rst_n;
    logic       nstart;
    logic       nstop;
    logic       mode;
    logic       halt;
    logic [2:0] beats;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } vec_t;

  logic       CLK = 1'b0;
  logic       nRst = 1'b0;
  logic       nSTART = 1'b1;
  logic       nSTOP = 1'b1;
  logic       mode = 1'b0;
  logic       halt = 1'b0;

  logic       t1, t2, t3, busy, done;
  logic [7:0] cyc_cnt;
  logic       t1_s, t2_s, t3_s, busy_s, done_s;
  logic [2:0] cyc_cnt_s;

  int n_cmp = 0;
  int n_bad = 0;
  int n_id  = 0;

  vec_t tbl[200];
  int   n_tbl = 0;
  vec_t exp_q[$];

  always #5 CLK = ~CLK;

  beat_ctrl dut (
    .CLK     (CLK),
    .nRst    (nRst),
    .nSTART  (nSTART),
    .nSTOP   (nSTOP),
    .mode    (mode),
    .halt    (halt),
    .t1      (t1),
    .t2      (t2),
    .t3      (t3),
    .busy    (busy),
    .done    (done),
    .cyc_cnt (cyc_cnt)
  );

  beat_ctrl #(.CNT_W(3)) dut_s (
    .CLK     (CLK),
    .nRst    (nRst),
    .nSTART  (nSTART),
    .nSTOP   (nSTOP),
    .mode    (mode),
    .halt    (halt),
    .t1      (t1_s),
    .t2      (t2_s),
    .t3      (t3_s),
    .busy    (busy_s),
    .done    (done_s),
    .cyc_cnt (cyc_cnt_s)
  );

  function automatic vec_t mk(input logic r, input logic ns, input logic np,
                              input logic md, input logic h, input logic [2:0] b,
                              input logic bz, input logic dn, input int c);
    vec_t v;
    n_id     = n_id + 1;
    v.id     = n_id;
    v.rst_n  = r;
    v.nstart = ns;
    v.nstop  = np;
    v.mode   = md;
    v.halt   = h;
    v.beats  = b;
    v.busy   = bz;
    v.done   = dn;
    v.cnt    = 8'(c);
    return v;
  endfunction

  function automatic void add(input vec_t v);
    tbl[n_tbl] = v;
    n_tbl      = n_tbl + 1;
  endfunction

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, id, act, exp);
    end
  endtask

  task automatic compare_out();
    vec_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("beats", e.id, 32'({t3, t2, t1}), 32'(e.beats));
      check("busy",  e.id, 32'(busy), 32'(e.busy));
      check("done",  e.id, 32'(done), 32'(e.done));
      check("cnt8",  e.id, 32'(cyc_cnt), 32'(e.cnt));
      check("ctl3",  e.id, 32'({t3_s, t2_s, t1_s, busy_s, done_s}),
            32'({e.beats, e.busy, e.done}));
      check("cnt3",  e.id, 32'(cyc_cnt_s), 32'(e.cnt[2:0]));
    end
  endtask

  // Inputs change on the falling edge; the expectation is checked on the
  // falling edge after the next rising edge.
  task automatic apply(input vec_t v);
    @(negedge CLK);
    compare_out();
    nRst   = v.rst_n;
    nSTART = v.nstart;
    nSTOP  = v.nstop;
    mode   = v.mode;
    halt   = v.halt;
    exp_q.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single STEP cycle; stop in STEP and in IDLE ignored.
    add(mk(0, 1, 1, 0, 0, 3'b000, 0, 0, 0));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 0));
    add(mk(1, 0, 1, 1, 0, 3'b001, 1, 0, 0));
    add(mk(1, 1, 0, 0, 0, 3'b010, 1, 0, 0));
    add(mk(1, 1, 1, 0, 0, 3'b100, 1, 0, 0));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 1, 1));
    add(mk(1, 1, 0, 0, 0, 3'b000, 0, 0, 1));
    // RUN, stop during the second t2: two full cycles.
    add(mk(0, 1, 1, 0, 0, 3'b000, 0, 0, 0));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 0));
    add(mk(1, 0, 1, 0, 0, 3'b001, 1, 0, 0));
    add(mk(1, 1, 1, 1, 0, 3'b010, 1, 0, 0));
    add(mk(1, 1, 1, 0, 0, 3'b100, 1, 0, 0));
    add(mk(1, 1, 1, 0, 0, 3'b001, 1, 0, 1));
    add(mk(1, 1, 1, 0, 0, 3'b010, 1, 0, 1));
    add(mk(1, 1, 0, 0, 0, 3'b100, 1, 0, 1));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 1, 2));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 2));
    // RUN with halt outside t3 ignored, start in RUN ignored, halt at 4th t3.
    add(mk(0, 1, 1, 0, 0, 3'b000, 0, 0, 0));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 0));
    add(mk(1, 0, 1, 0, 0, 3'b001, 1, 0, 0));
    add(mk(1, 1, 1, 0, 1, 3'b010, 1, 0, 0));
    add(mk(1, 1, 1, 0, 1, 3'b100, 1, 0, 0));
    add(mk(1, 1, 1, 0, 0, 3'b001, 1, 0, 1));
    add(mk(1, 1, 1, 0, 1, 3'b010, 1, 0, 1));
    add(mk(1, 1, 1, 0, 1, 3'b100, 1, 0, 1));
    add(mk(1, 1, 1, 0, 0, 3'b001, 1, 0, 2));
    add(mk(1, 0, 1, 0, 0, 3'b010, 1, 0, 2));
    add(mk(1, 1, 1, 0, 0, 3'b100, 1, 0, 2));
    add(mk(1, 1, 1, 0, 0, 3'b001, 1, 0, 3));
    add(mk(1, 1, 1, 0, 0, 3'b010, 1, 0, 3));
    add(mk(1, 1, 1, 0, 0, 3'b100, 1, 0, 3));
    add(mk(1, 1, 1, 0, 1, 3'b000, 0, 1, 4));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 4));
    // Start and stop together in IDLE: stop wins.
    add(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 4));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 4));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 4));
    // Stop inside t3 ends that cycle; pending stop clears for the next run.
    add(mk(1, 0, 1, 0, 0, 3'b001, 1, 0, 4));
    add(mk(1, 1, 1, 0, 0, 3'b010, 1, 0, 4));
    add(mk(1, 1, 1, 0, 0, 3'b100, 1, 0, 4));
    add(mk(1, 1, 0, 0, 0, 3'b000, 0, 1, 5));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 5));
    add(mk(1, 0, 1, 0, 0, 3'b001, 1, 0, 5));
    add(mk(1, 1, 1, 0, 0, 3'b010, 1, 0, 5));
    add(mk(1, 1, 1, 0, 0, 3'b100, 1, 0, 5));
    add(mk(1, 1, 1, 0, 0, 3'b001, 1, 0, 6));
    add(mk(1, 1, 1, 0, 0, 3'b010, 1, 0, 6));
    add(mk(1, 1, 1, 0, 0, 3'b100, 1, 0, 6));
    add(mk(1, 1, 1, 0, 1, 3'b000, 0, 1, 7));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 7));
    // Nine RUN cycles: the 3-bit counter wraps after the eighth.
    add(mk(0, 1, 1, 0, 0, 3'b000, 0, 0, 0));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 0));
    add(mk(1, 0, 1, 0, 0, 3'b001, 1, 0, 0));
    for (int c = 1; c <= 8; c++) begin
      add(mk(1, 1, 1, 0, 0, 3'b010, 1, 0, c - 1));
      add(mk(1, 1, 1, 0, 0, 3'b100, 1, 0, c - 1));
      add(mk(1, 1, 1, 0, 0, 3'b001, 1, 0, c));
    end
    add(mk(1, 1, 0, 0, 0, 3'b010, 1, 0, 8));
    add(mk(1, 1, 1, 0, 0, 3'b100, 1, 0, 8));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 1, 9));
    add(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 9));

    for (int i = 0; i < n_tbl; i++) apply(tbl[i]);

    // Reset at t2 of RUN with nSTART held low through release.
    apply(mk(1, 0, 1, 0, 0, 3'b001, 1, 0, 9));
    apply(mk(1, 1, 1, 0, 0, 3'b010, 1, 0, 9));
    apply(mk(0, 0, 1, 0, 0, 3'b000, 0, 0, 0));
    apply(mk(0, 0, 1, 0, 0, 3'b000, 0, 0, 0));
    apply(mk(1, 0, 1, 0, 0, 3'b000, 0, 0, 0));
    apply(mk(1, 0, 1, 0, 0, 3'b000, 0, 0, 0));
    apply(mk(1, 0, 1, 0, 0, 3'b000, 0, 0, 0));
    apply(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 0));
    apply(mk(1, 0, 1, 1, 0, 3'b001, 1, 0, 0));
    apply(mk(1, 1, 1, 0, 0, 3'b010, 1, 0, 0));
    apply(mk(1, 1, 1, 0, 0, 3'b100, 1, 0, 0));
    apply(mk(1, 1, 1, 0, 0, 3'b000, 0, 1, 1));
    apply(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 1));

    @(negedge CLK);
    compare_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
